// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with a combinational logic/arith/shift/compare path and an
// iterative radix-2 multiply/divide unit that writes the HI/LO result registers.
module alu_md #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    input  logic             start,
    output logic [WIDTH-1:0] aluResult,
    output logic             aluZero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q;      // partial product high half / partial remainder
    logic [WIDTH-1:0] mq_q;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] mcand_q;    // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_save_q;   // raw dividend, returned in hi on divide by zero
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    // ---------------- combinational ALU ----------------
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign shamt = B[SHW-1:0];
    assign sum   = A + B;
    assign diff  = A - B;

    // Decode the ALU operation into a result and signed-overflow flag
    always_comb begin
        aluResult = '0;
        overflow  = 1'b0;
        case (ALUop)
            4'b0000: aluResult = A & B;
            4'b0001: aluResult = A | B;
            4'b0010: begin
                aluResult = sum;
                overflow  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0011: aluResult = A ^ B;
            4'b0100: aluResult = ~(A | B);
            4'b0101: aluResult = {{(WIDTH-1){1'b0}}, (A < B)};
            4'b0110: begin
                aluResult = diff;
                overflow  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0111: aluResult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1000: aluResult = A << shamt;
            4'b1001: aluResult = A >> shamt;
            4'b1010: aluResult = unsigned'($signed(A) >>> shamt);
            4'b1011: aluResult = '0;
            default: aluResult = lo_q;
        endcase
    end

    assign aluZero = (aluResult == '0);

    // ---------------- multiply / divide datapath ----------------
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes at launch, one step of each algorithm, and final sign fix-up
    always_comb begin
        op_signed = ~ALUop[0];
        a_neg     = op_signed & A[WIDTH-1];
        b_neg     = op_signed & B[WIDTH-1];
        mag_a     = a_neg ? -A : A;
        mag_b     = b_neg ? -B : B;

        mul_sum   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};

        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_sub   = div_shift - {1'b0, mcand_q};

        prod      = {acc_q, mq_q};
        prod_fix  = neg_res_q ? -prod : prod;
        quot_fix  = neg_res_q ? -mq_q : mq_q;
        rem_fix   = neg_rem_q ? -acc_q : acc_q;
    end

    // Sequencer: IDLE -> RUN (WIDTH steps) -> FIN (write hi/lo, pulse done)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            mcand_q    <= '0;
            a_save_q   <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && (ALUop[3:2] == 2'b11)) begin
                        is_div_q   <= ALUop[1];
                        acc_q      <= '0;
                        mq_q       <= ALUop[1] ? mag_a : mag_b;
                        mcand_q    <= ALUop[1] ? mag_b : mag_a;
                        a_save_q   <= A;
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (B == '0);
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (is_div_q) begin
                        acc_q <= div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        mq_q  <= {mq_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_q <= mul_sum[WIDTH:1];
                        mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + SHW'(1);
                    if (cnt_q == LastCnt) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (div_zero_q) begin
                        hi_q <= a_save_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): a cycle-level reference model plus directed vectors.
module tb_alu_md;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUop;
    logic             start;
    logic [WIDTH-1:0] aluResult;
    logic             aluZero;
    logic             overflow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    alu_md #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .ALUop     (ALUop),
        .start     (start),
        .aluResult (aluResult),
        .aluZero   (aluZero),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] comb_model(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] lo_v);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: return 32'($signed(a) >>> sh);
            4'd11: return 32'd0;
            default: return lo_v;
        endcase
    endfunction

    function automatic logic ov_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (op == 4'd2)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 4'd6) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] md_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int q, r;
        case (op[1:0])
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    // Model state advances on each rising edge from the inputs present before it
    always @(posedge clk) begin : model
        logic        nb, nd;
        logic [31:0] nh, nl, ph, pl;
        int          left;
        logic [63:0] r;
        nb = m_busy; nd = 1'b0; nh = m_hi; nl = m_lo; ph = p_hi; pl = p_lo; left = m_left;
        if (reset) begin
            nb = 0; nh = 0; nl = 0; left = 0;
        end else begin
            if (m_busy) begin
                left = left - 1;
                if (left == 0) begin
                    nb = 0; nd = 1; nh = p_hi; nl = p_lo;
                end
            end
            if (!m_busy && start && ALUop[3:2] == 2'b11) begin
                nb = 1; left = WIDTH + 1;
                r = md_model(ALUop, A, B);
                ph = r[63:32]; pl = r[31:0];
            end
        end
        m_busy <= nb; m_done <= nd; m_hi <= nh; m_lo <= nl;
        p_hi <= ph; p_lo <= pl; m_left <= left;
    end

    // Compare every observable output against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("aluResult", aluResult, comb_model(ALUop, A, B, m_lo));
            check("aluZero", aluZero, comb_model(ALUop, A, B, m_lo) == 0);
            check("overflow", overflow, ov_model(ALUop, A, B));
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic comb_case(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] er, input logic ez, input logic eo);
        @(posedge clk); #1;
        ALUop = op; A = a; B = b; start = 0;
        @(negedge clk);
        check({name, ".res"}, aluResult, er);
        check({name, ".zero"}, aluZero, ez);
        check({name, ".ovf"}, overflow, eo);
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        ALUop = op; A = a; B = b; start = 1;
        @(posedge clk); #1;
        start = 0; A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(input string name, output int busy_cycles);
        bit got;
        got = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (busy) busy_cycles++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s.timeout actual=no_done required=done", name);
        end
    endtask

    task automatic md_case(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int bc;
        launch(op, a, b);
        wait_done(name, bc);
        check({name, ".lat"}, bc, 33);
        check({name, ".hi"}, hi, eh);
        check({name, ".lo"}, lo, el);
    endtask

    initial begin
        int bc;
        int dones;
        reset = 1; start = 0; A = 0; B = 0; ALUop = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.hi", hi, 0);
        check("rst.lo", lo, 0);
        @(posedge clk); #1;
        reset = 0;

        comb_case("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1);
        comb_case("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1, 0);
        comb_case("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1);
        comb_case("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0);
        comb_case("sltu", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        comb_case("sra", 4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0);
        comb_case("srl", 4'b1001, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0);
        comb_case("sll", 4'b1000, 32'd1, 32'h0000_0FFF, 32'h8000_0000, 0, 0);
        comb_case("nor", 4'b0100, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0);
        comb_case("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 0, 0);
        comb_case("or", 4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0, 0);
        comb_case("xor", 4'b0011, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd0, 1, 0);
        comb_case("op1011", 4'b1011, 32'h1234, 32'h5678, 32'd0, 1, 0);

        md_case("mult", 4'b1100, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(negedge clk);
        check("mult.done_fall", done, 0);
        comb_case("mflo", 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFEB, 0, 0);
        md_case("multu", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        md_case("div", 4'b1110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_case("divu0", 4'b1111, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        md_case("divmin", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        md_case("div_neg", 4'b1110, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

        // Second start mid-operation must be ignored
        launch(4'b1100, 32'd100, 32'd200);
        repeat (4) @(posedge clk);
        #1; ALUop = 4'b1101; A = 32'd7; B = 32'd9; start = 1;
        @(posedge clk); #1; start = 0;
        wait_done("ignored", bc);
        check("ignored.hi", hi, 32'd0);
        check("ignored.lo", lo, 32'd20000);

        // Back-to-back: start presented during the done cycle
        launch(4'b1101, 32'd6, 32'd7);
        wait_done("b2b_first", bc);
        check("b2b_first.lo", lo, 32'd42);
        #2; ALUop = 4'b1111; A = 32'd100; B = 32'd7; start = 1;
        @(posedge clk); #1; start = 0;
        wait_done("b2b_second", bc);
        check("b2b_second.lat", bc, 33);
        check("b2b_second.hi", hi, 32'd2);
        check("b2b_second.lo", lo, 32'd14);

        // Reset mid-operation aborts with no done pulse
        launch(4'b1111, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1; reset = 1;
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        check("abort.busy", busy, 0);
        check("abort.hi", hi, 0);
        check("abort.lo", lo, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort.no_done", dones, 0);
        md_case("after_abort", 4'b1101, 32'd3, 32'd4, 32'd0, 32'd12);

        // Reset wins over a simultaneous start
        @(posedge clk); #1;
        reset = 1; start = 1; ALUop = 4'b1100; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        reset = 0; start = 0;
        @(negedge clk);
        check("rst_start.busy", busy, 0);
        repeat (3) @(negedge clk);
        check("rst_start.idle", busy, 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
